// File: rtl/clm_rand_src.sv
// Random reduction-polynomial source: a 32-bit Galois LFSR feeds a d-bit word
// assembler and a 2-entry FIFO. Optional macro CLM_RAND_REJECT_ZERO_EN drops all-zero words.
module clm_rand_src #(
    parameter int          d    = 2,
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  seed_i,
    input  logic         seed_valid_i,
    output logic [d-1:0] r_o,
    output logic         r_valid_o,
    input  logic         r_ready_i
);

    typedef logic [d-1:0] red_poly_t;
    typedef enum logic {FILL, HOLD} state_t;

    localparam logic [31:0] MASK     = 32'h8020_0003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam int          CW       = (d > 1) ? $clog2(d) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(d - 1);

    logic [31:0]   lfsr_q, lfsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    red_poly_t     acc_q, acc_d;
    red_poly_t     mem_q [2];
    red_poly_t     mem_d [2];
    logic          head_q, head_d, tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    state_t        state_q, state_d;

    logic          bit_w, advance, word_done, push, pop;
    logic [31:0]   lfsr_step;
    red_poly_t     acc_nxt;

    always_comb begin
        bit_w     = lfsr_q[0];
        lfsr_step = (lfsr_q >> 1) ^ (bit_w ? MASK : 32'h0);
        acc_nxt   = acc_q;
        acc_nxt[cnt_q] = bit_w;
        advance   = (state_q == FILL);
        word_done = advance && (cnt_q == CNT_LAST);
`ifdef CLM_RAND_REJECT_ZERO_EN
        push      = word_done && (acc_nxt != '0);
`else
        push      = word_done;
`endif
        pop       = r_ready_i && (count_q != 2'd0);
    end

    always_comb begin
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        state_d = state_q;
        if (seed_valid_i) begin
            // Reseed flushes everything; concurrent push/pop are dropped.
            lfsr_d  = (seed_i == 32'h0) ? 32'h1 : seed_i;
            cnt_d   = '0;
            acc_d   = '0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
            state_d = FILL;
        end else begin
            if (advance) begin
                lfsr_d = lfsr_step;
                acc_d  = acc_nxt;
                cnt_d  = word_done ? '0 : CW'(cnt_q + 1'b1);
            end
            if (push) begin
                mem_d[tail_q] = acc_nxt;
                tail_d        = ~tail_q;
            end
            if (pop)
                head_d = ~head_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            case (state_q)
                FILL: if (push && !pop && count_q == 2'd1) state_d = HOLD;
                HOLD: if (pop) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q   <= SEED_EFF;
            cnt_q    <= '0;
            acc_q    <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            count_q  <= 2'd0;
            state_q  <= FILL;
        end else begin
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign r_valid_o = (count_q != 2'd0);
    assign r_o       = r_valid_o ? mem_q[head_q] : '0;

endmodule

// File: tb/tb_clm_rand_src.sv
// Directed bench for clm_rand_src (d=2, SEED=1): vector table plus corner-case sequences.
module tb_clm_rand_src;

    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  seed_i;
    logic         seed_valid_i;
    logic [D-1:0] r_o;
    logic         r_valid_o;
    logic         r_ready_i;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [D-1:0] exp_q [$];
    logic [D-1:0] got_q [$];

    typedef struct {
        logic         rdy;
        logic         v;
        logic [D-1:0] r;
    } vec_t;
    vec_t tbl [8];

    clm_rand_src #(.d(D), .SEED(32'h0000_0001)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seed_i       (seed_i),
        .seed_valid_i (seed_valid_i),
        .r_o          (r_o),
        .r_valid_o    (r_valid_o),
        .r_ready_i    (r_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples land 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; seed_valid_i = 1'b0; r_ready_i = 1'b0; seed_i = '0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic gen_model(input logic [31:0] seed, input int n);
        logic [31:0]  l;
        logic [D-1:0] w;
        l = seed;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < D; i++) begin
                w[i] = l[0];
                l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
            end
            exp_q.push_back(w);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 2'b00};
        tbl[1] = '{1'b1, 1'b1, 2'b11};
        tbl[2] = '{1'b1, 1'b0, 2'b00};
        tbl[3] = '{1'b1, 1'b1, 2'b10};
        tbl[4] = '{1'b1, 1'b0, 2'b00};
        tbl[5] = '{1'b1, 1'b1, 2'b01};
        tbl[6] = '{1'b1, 1'b0, 2'b00};
        tbl[7] = '{1'b1, 1'b1, 2'b11};

        rst_n = 1'b0; seed_valid_i = 1'b0; r_ready_i = 1'b0; seed_i = '0;
        #3;
        check("reset_valid", {31'b0, r_valid_o}, 32'd0);
        check("reset_r", {30'b0, r_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset release, consumer always ready
        for (int i = 0; i < 8; i++) begin
            r_ready_i = tbl[i].rdy;
            tick(1);
            check($sformatf("tbl%0d_valid", i), {31'b0, r_valid_o}, {31'b0, tbl[i].v});
            check($sformatf("tbl%0d_r", i), {30'b0, r_o}, {30'b0, tbl[i].r});
        end

        // Stall from reset: fill, hold 20 cycles, then drain
        do_reset();
        tick(4);
        check("stall_full_r", {30'b0, r_o}, 32'h3);
        tick(20);
        check("stall_hold_v", {31'b0, r_valid_o}, 32'd1);
        check("stall_hold_r", {30'b0, r_o}, 32'h3);
        r_ready_i = 1'b1;
        tick(1);
        check("stall_pop1_r", {30'b0, r_o}, 32'h2);
        tick(1);
        check("stall_empty_v", {31'b0, r_valid_o}, 32'd0);
        tick(1);
        check("stall_third_v", {31'b0, r_valid_o}, 32'd1);
        check("stall_third_r", {30'b0, r_o}, 32'h1);

        // Push and pop on the same edge at count 1
        do_reset();
        tick(3);
        check("pp_pre_r", {30'b0, r_o}, 32'h3);
        r_ready_i = 1'b1;
        tick(1);
        check("pp_same_v", {31'b0, r_valid_o}, 32'd1);
        check("pp_same_r", {30'b0, r_o}, 32'h2);
        r_ready_i = 1'b0;
        tick(1);
        r_ready_i = 1'b1;
        tick(1);
        check("pp_next_r", {30'b0, r_o}, 32'h1);
        tick(1);
        check("pp_count1_v", {31'b0, r_valid_o}, 32'd0);

        // Reseed with zero mid-word while one word is buffered
        do_reset();
        tick(3);
        check("rs_pre_v", {31'b0, r_valid_o}, 32'd1);
        seed_i = 32'h0; seed_valid_i = 1'b1;
        tick(1);
        seed_valid_i = 1'b0;
        check("rs_flush_v", {31'b0, r_valid_o}, 32'd0);
        r_ready_i = 1'b1;
        tick(1);
        check("rs_e1_v", {31'b0, r_valid_o}, 32'd0);
        tick(1);
        check("rs_w1_r", {30'b0, r_o}, 32'h3);
        tick(2);
        check("rs_w2_r", {30'b0, r_o}, 32'h2);

        // Seed 4 yields an all-zero first word
        do_reset();
        seed_i = 32'h4; seed_valid_i = 1'b1; r_ready_i = 1'b1;
        tick(1);
        seed_valid_i = 1'b0;
        check("s4_flush_v", {31'b0, r_valid_o}, 32'd0);
        tick(2);
`ifdef CLM_RAND_REJECT_ZERO_EN
        check("s4_e2_v", {31'b0, r_valid_o}, 32'd0);
`else
        check("s4_e2_v", {31'b0, r_valid_o}, 32'd1);
        check("s4_e2_r", {30'b0, r_o}, 32'h0);
`endif
        tick(2);
        check("s4_e4_v", {31'b0, r_valid_o}, 32'd1);
        check("s4_e4_r", {30'b0, r_o}, 32'h3);

        // Async reset while full and holding
        do_reset();
        tick(6);
        check("ar_full_v", {31'b0, r_valid_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_async_v", {31'b0, r_valid_o}, 32'd0);
        check("ar_async_r", {30'b0, r_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        r_ready_i = 1'b1;
        tick(2);
        check("ar_restart_r", {30'b0, r_o}, 32'h3);

        // Random stalls must not change the delivered sequence
        do_reset();
        got_q.delete();
        for (int c = 0; c < 200; c++) begin
            r_ready_i = 1'($urandom_range(0, 1));
            if (r_valid_o && r_ready_i) got_q.push_back(r_o);
            tick(1);
        end
        r_ready_i = 1'b0;
        gen_model(32'h1, got_q.size());
        check("rand_count_ok", {31'b0, got_q.size() >= 10}, 32'd1);
        for (int k = 0; k < got_q.size(); k++)
            check($sformatf("rand_w%0d", k), {30'b0, got_q[k]}, {30'b0, exp_q[k]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/clm_rand_src.md
# clm_rand_src

Randomness source for the CLM masked datapath. It produces a stream of fresh `d`-bit random reduction polynomials (`red_poly_t`) from a 32-bit Galois LFSR and buffers them in a 2-entry FIFO. Words are delivered over a valid/ready handshake to the polynomial-by-matrix multiplier stage, which consumes one `r` per masking operation. A seed port allows runtime reseeding, which flushes all buffered randomness.

## Interface
- `d`, default 2: masking order; width of each output word (`red_poly_t`); legal range 1..32.
- `SEED`, default 32'hACE1_2468: LFSR value loaded at reset (zero value replaced by 32'h0000_0001).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `seed_i`  in  32  new LFSR seed.
- `seed_valid_i`  in  1  load `seed_i` at this edge; single-cycle strobe.
- `r_o`  out  `d` (`red_poly_t`)  head-of-FIFO random word; 0 when FIFO empty.
- `r_valid_o`  out  1  FIFO non-empty.
- `r_ready_i`  in  1  consumer accepts `r_o` at this edge when `r_valid_o`=1.

## Operation
- LFSR: right-shift Galois, mask 32'h8020_0003 (x^32+x^22+x^2+x+1). Per step: `b = lfsr[0]`; `lfsr <= (lfsr >> 1) ^ (b ? 32'h8020_0003 : 0)`.
- Assembly: bit counter `cnt` (0..d-1) and shift register `acc`. Each advancing cycle writes `b` into `acc[cnt]`; at `cnt == d-1` the completed word (`acc` with bit d-1 = `b`) is pushed and `cnt` wraps to 0.
- State machine: FILL (LFSR and `cnt` advance) and HOLD (LFSR, `cnt` and `acc` frozen).
  - FILL -> HOLD: a push takes FIFO count to 2 with no simultaneous pop.
  - HOLD -> FILL: a pop occurs (count drops to 1).
  - While FIFO count = 2 but a pop occurs in the same cycle, the block stays in FILL and advances.
- FIFO: 2 entries, head/tail pointers plus a 2-bit count. Simultaneous push and pop leaves the count unchanged, and the popped entry is the old head. A pop while empty is ignored.
- Reseed (`seed_valid_i`=1) has priority over every other event:
  - `lfsr <= (seed_i == 0) ? 1 : seed_i`, `cnt <= 0`, `acc <= 0`, FIFO count <= 0, state <= FILL.
  - A push or pop in the same cycle is discarded.
- Reset values: `lfsr` = SEED (or 1 if zero), `cnt` = 0, `acc` = 0, FIFO empty, state FILL, `r_o` = 0, `r_valid_o` = 0.
- Asserting `rst_n` low mid-word or with a non-empty FIFO discards all contents immediately. This is an asynchronous clear.

## Timing
- All outputs are registered or decoded from registers only; there is no combinational path from `r_ready_i` or `seed_i` to any output.
- First word: pushed at the d-th rising edge after reset release; `r_valid_o` is high from that edge.
- Steady state with the consumer always ready: one word every d cycles, so `r_valid_o` pulses one cycle in every d when d > 1, and stays continuously high when d = 1.
- After a pop, `r_o` shows the next entry on the same edge.
- Reseed: `r_valid_o` = 0 from the reseed edge. The first word from the new seed is pushed d edges later.
- FIFO full with no pop: LFSR state is unchanged indefinitely. The output sequence depends only on the seed, never on consumer stall pattern.

## Configuration
- `CLM_RAND_REJECT_ZERO_EN`:
  - Defined: a completed all-zero word is not pushed. The LFSR and `cnt` still advance, and the state does not change.
  - Undefined: every completed word is pushed, including zero.

## Test plan
- Reset release (d=2, seed 32'h0000_0001, consumer ready) -> words 2'b11, then 2'b10; first `r_valid_o` at edge 2, second at edge 4.
- Consumer stalled from reset (d=2, seed 1) -> FIFO fills with 2'b11, 2'b10 by edge 4 and the state enters HOLD. After 20 stall cycles, raise `r_ready_i` -> pops 2'b11, 2'b10; the next word equals the third word of the unstalled run.
- Simultaneous push and pop with count = 1 -> count stays 1, `r_o` advances to the next entry, and no word is lost or duplicated versus the reference LFSR model.
- Reseed with seed_i = 0 mid-word while FIFO holds 1 entry -> `r_valid_o` = 0 on the next cycle, LFSR = 1, and the subsequent stream is 2'b11, 2'b10.
- Seed 32'h0000_0004, d=2:
  - With `CLM_RAND_REJECT_ZERO_EN` defined -> the first delivered word is 2'b11, at edge 4.
  - With it undefined -> words 2'b00 (edge 2), then 2'b11 (edge 4).
- Async reset asserted while FIFO full and in HOLD -> `r_valid_o` = 0 and `r_o` = 0 immediately, without waiting for a clock edge. After release, the stream restarts from SEED.
